// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the TMR multiplier fault monitor.
//
// Contents:
//   mon_state_e      health state of the triplicated multiplier
//   REPLICA_NONE..C  replica encoding used on culprit/alarm outputs
package cv32e40p_pkg;

    // Health of the replica set, ordered from fully healthy to untrustworthy
    typedef enum logic [1:0] {
        MON_OK      = 2'd0,
        MON_SUSPECT = 2'd1,
        MON_FAILED  = 2'd2,
        MON_UNCORR  = 2'd3
    } mon_state_e;

    localparam logic [1:0] REPLICA_NONE = 2'd0;
    localparam logic [1:0] REPLICA_A    = 2'd1;
    localparam logic [1:0] REPLICA_B    = 2'd2;
    localparam logic [1:0] REPLICA_C    = 2'd3;

endpackage

// File: rtl/cv32e40p_tmr_disagree.sv
// Combinational majority classifier for three W-bit replica vectors.
//
// Ports:
//   vec_a, vec_b, vec_c  in   W  replica vectors
//   culprit              out  2  replica outvoted by the other two (REPLICA_NONE if all agree)
//   uncorr               out  1  no two replicas agree
module cv32e40p_tmr_disagree
    import cv32e40p_pkg::*;
#(
    parameter int W = 35
) (
    input  logic [W-1:0] vec_a,
    input  logic [W-1:0] vec_b,
    input  logic [W-1:0] vec_c,
    output logic [1:0]   culprit,
    output logic         uncorr
);

    logic eq_ab;
    logic eq_ac;
    logic eq_bc;

    assign eq_ab = (vec_a == vec_b);
    assign eq_ac = (vec_a == vec_c);
    assign eq_bc = (vec_b == vec_c);

    // The replica left out of the agreeing pair is the culprit. When a==b and
    // a==c all three agree, so that case is tested first.
    always_comb begin
        culprit = REPLICA_NONE;
        uncorr  = 1'b0;
        if (eq_ab && eq_ac) begin
            culprit = REPLICA_NONE;
        end else if (eq_ab) begin
            culprit = REPLICA_C;
        end else if (eq_ac) begin
            culprit = REPLICA_B;
        end else if (eq_bc) begin
            culprit = REPLICA_A;
        end else begin
            uncorr = 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_mult_fault_monitor.sv
// Fault monitor for the triplicated multiplier. Observes the three replica
// outputs whenever the voted result is consumed, attributes disagreements to a
// replica, counts them and classifies the fault. Status only; the voted
// datapath is never touched.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   sample_i                      replica outputs valid this cycle
//   res_{a,b,c}_i  [DATA_W]       replica results
//   ctrl_{a,b,c}_i [3]            replica {multicycle, mulh_active, ready}
//   clear_i                       synchronous clear of counters, state and alarms
//   mismatch_o                    last sample had any disagreement
//   culprit_o      [2]            replica of the last single mismatch
//   err_cnt_{a,b,c}_o [CNT_W]     saturating per-replica mismatch counts
//   alarm_o, alarm_replica_o [2]  sticky persistent-fault alarm and its replica
//   uncorrectable_o               sticky: majority no longer trustworthy
//   state_o        [2]            mon_state_e
module cv32e40p_tmr_mult_fault_monitor
    import cv32e40p_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 8,
    parameter int PERSIST_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_i,
    input  logic [DATA_W-1:0] res_a_i,
    input  logic [DATA_W-1:0] res_b_i,
    input  logic [DATA_W-1:0] res_c_i,
    input  logic [2:0]        ctrl_a_i,
    input  logic [2:0]        ctrl_b_i,
    input  logic [2:0]        ctrl_c_i,
    input  logic              clear_i,
    output logic              mismatch_o,
    output logic [1:0]        culprit_o,
    output logic [CNT_W-1:0]  err_cnt_a_o,
    output logic [CNT_W-1:0]  err_cnt_b_o,
    output logic [CNT_W-1:0]  err_cnt_c_o,
    output logic              alarm_o,
    output logic [1:0]        alarm_replica_o,
    output logic              uncorrectable_o,
    output logic [1:0]        state_o
);

    localparam int                CONS_W     = $clog2(PERSIST_THRESH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CONS_W-1:0] CONS_LAST  = CONS_W'(PERSIST_THRESH - 1);
    localparam logic [CONS_W-1:0] CONS_ONE   = CONS_W'(1);

    logic [1:0] cls_culprit;
    logic       cls_uncorr;

    // Control bits are compared together with the result so that a replica
    // with a wrong handshake is caught even when its data happens to match.
    cv32e40p_tmr_disagree #(
        .W (DATA_W + 3)
    ) u_disagree (
        .vec_a   ({ctrl_a_i, res_a_i}),
        .vec_b   ({ctrl_b_i, res_b_i}),
        .vec_c   ({ctrl_c_i, res_c_i}),
        .culprit (cls_culprit),
        .uncorr  (cls_uncorr)
    );

    mon_state_e        state_q,      state_d;
    logic [1:0]        track_q,      track_d;
    logic [CONS_W-1:0] consec_q,     consec_d;
    logic [CNT_W-1:0]  cnt_a_q,      cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q,      cnt_b_d;
    logic [CNT_W-1:0]  cnt_c_q,      cnt_c_d;
    logic              mismatch_q,   mismatch_d;
    logic [1:0]        culprit_q,    culprit_d;
    logic              alarm_q,      alarm_d;
    logic [1:0]        alarm_rep_q,  alarm_rep_d;
    logic              uncorr_q,     uncorr_d;
    logic              single;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign single = (cls_culprit != REPLICA_NONE);

    // Next-state logic. Clear wins over a sample in the same cycle. Once the
    // monitor is UNCORR every piece of bookkeeping is frozen; a fresh UNCORR
    // classification still forces UNCORR from any state. A single mismatch
    // while FAILED is still counted, even when it is the one that moves the
    // monitor to UNCORR.
    always_comb begin
        state_d     = state_q;
        track_d     = track_q;
        consec_d    = consec_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        cnt_c_d     = cnt_c_q;
        mismatch_d  = sample_i && (single || cls_uncorr);
        culprit_d   = culprit_q;
        alarm_d     = alarm_q;
        alarm_rep_d = alarm_rep_q;
        uncorr_d    = uncorr_q;

        if (clear_i) begin
            state_d     = MON_OK;
            track_d     = REPLICA_NONE;
            consec_d    = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            cnt_c_d     = '0;
            mismatch_d  = 1'b0;
            culprit_d   = REPLICA_NONE;
            alarm_d     = 1'b0;
            alarm_rep_d = REPLICA_NONE;
            uncorr_d    = 1'b0;
        end else if (sample_i) begin
            if (cls_uncorr) begin
                state_d  = MON_UNCORR;
                uncorr_d = 1'b1;
            end else if (single && state_q != MON_UNCORR) begin
                culprit_d = cls_culprit;
                case (cls_culprit)
                    REPLICA_A: cnt_a_d = sat_inc(cnt_a_q);
                    REPLICA_B: cnt_b_d = sat_inc(cnt_b_q);
                    default:   cnt_c_d = sat_inc(cnt_c_q);
                endcase
                case (state_q)
                    MON_OK: begin
                        state_d  = MON_SUSPECT;
                        track_d  = cls_culprit;
                        consec_d = CONS_ONE;
                    end
                    MON_SUSPECT: begin
                        if (cls_culprit == track_q) begin
                            consec_d = consec_q + CONS_ONE;
                            if (consec_q == CONS_LAST) begin
                                state_d     = MON_FAILED;
                                alarm_d     = 1'b1;
                                alarm_rep_d = track_q;
                            end
                        end else begin
                            track_d  = cls_culprit;
                            consec_d = CONS_ONE;
                        end
                    end
                    MON_FAILED: begin
                        if (cls_culprit != alarm_rep_q) begin
                            state_d  = MON_UNCORR;
                            uncorr_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (!single && state_q == MON_SUSPECT) begin
                state_d  = MON_OK;
                consec_d = '0;
            end
        end
    end

    // State and output registers; reset returns everything to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MON_OK;
            track_q     <= REPLICA_NONE;
            consec_q    <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            cnt_c_q     <= '0;
            mismatch_q  <= 1'b0;
            culprit_q   <= REPLICA_NONE;
            alarm_q     <= 1'b0;
            alarm_rep_q <= REPLICA_NONE;
            uncorr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            track_q     <= track_d;
            consec_q    <= consec_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            cnt_c_q     <= cnt_c_d;
            mismatch_q  <= mismatch_d;
            culprit_q   <= culprit_d;
            alarm_q     <= alarm_d;
            alarm_rep_q <= alarm_rep_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign mismatch_o      = mismatch_q;
    assign culprit_o       = culprit_q;
    assign err_cnt_a_o     = cnt_a_q;
    assign err_cnt_b_o     = cnt_b_q;
    assign err_cnt_c_o     = cnt_c_q;
    assign alarm_o         = alarm_q;
    assign alarm_replica_o = alarm_rep_q;
    assign uncorrectable_o = uncorr_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cv32e40p_tmr_mult_fault_monitor.sv
// Self-checking bench for the TMR multiplier fault monitor. Two instances share
// the same stimulus: one with default parameters and one with 2-bit counters
// to reach saturation quickly. Each is tracked by its own reference model.
module tb_cv32e40p_tmr_mult_fault_monitor;

    localparam int DW     = 32;
    localparam int THRESH = 4;

    logic          clk;
    logic          rst_n;
    logic          sample;
    logic [DW-1:0] res_a, res_b, res_c;
    logic [2:0]    ctrl_a, ctrl_b, ctrl_c;
    logic          clear;

    logic       mis0, alarm0, unc0;
    logic [1:0] cul0, arep0, st0;
    logic [7:0] ca0, cb0, cc0;
    logic       mis1, alarm1, unc1;
    logic [1:0] cul1, arep1, st1;
    logic [1:0] ca1, cb1, cc1;

    cv32e40p_tmr_mult_fault_monitor #(
        .DATA_W(DW), .CNT_W(8), .PERSIST_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_i(sample),
        .res_a_i(res_a), .res_b_i(res_b), .res_c_i(res_c),
        .ctrl_a_i(ctrl_a), .ctrl_b_i(ctrl_b), .ctrl_c_i(ctrl_c),
        .clear_i(clear), .mismatch_o(mis0), .culprit_o(cul0),
        .err_cnt_a_o(ca0), .err_cnt_b_o(cb0), .err_cnt_c_o(cc0),
        .alarm_o(alarm0), .alarm_replica_o(arep0),
        .uncorrectable_o(unc0), .state_o(st0)
    );

    cv32e40p_tmr_mult_fault_monitor #(
        .DATA_W(DW), .CNT_W(2), .PERSIST_THRESH(THRESH)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .sample_i(sample),
        .res_a_i(res_a), .res_b_i(res_b), .res_c_i(res_c),
        .ctrl_a_i(ctrl_a), .ctrl_b_i(ctrl_b), .ctrl_c_i(ctrl_c),
        .clear_i(clear), .mismatch_o(mis1), .culprit_o(cul1),
        .err_cnt_a_o(ca1), .err_cnt_b_o(cb1), .err_cnt_c_o(cc1),
        .alarm_o(alarm1), .alarm_replica_o(arep1),
        .uncorrectable_o(unc1), .state_o(st1)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: states 0 OK, 1 SUSPECT, 2 FAILED, 3 UNCORR;
    // replica ids 1..3, 0 = none. Index 0 = default DUT, 1 = small DUT.
    int mSt[2], mTrack[2], mConsec[2], mCul[2], mMis[2];
    int mAlarm[2], mARep[2], mUnc[2];
    int mCnt[2][3];
    int maxCnt[2] = '{255, 3};

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mSt[i] = 0; mTrack[i] = 0; mConsec[i] = 0; mCul[i] = 0;
            mMis[i] = 0; mAlarm[i] = 0; mARep[i] = 0; mUnc[i] = 0;
            for (int r = 0; r < 3; r++) mCnt[i][r] = 0;
        end
    endtask

    // Which replica is outvoted: 0 all agree, 1..3 single culprit, 4 none agree
    function automatic int modelClassify();
        logic [DW+2:0] va, vb, vc;
        va = {ctrl_a, res_a};
        vb = {ctrl_b, res_b};
        vc = {ctrl_c, res_c};
        if (va == vb && vb == vc) return 0;
        if (va == vb) return 3;
        if (va == vc) return 2;
        if (vb == vc) return 1;
        return 4;
    endfunction

    task automatic modelStep(input int cls);
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                mSt[i] = 0; mTrack[i] = 0; mConsec[i] = 0; mCul[i] = 0;
                mMis[i] = 0; mAlarm[i] = 0; mARep[i] = 0; mUnc[i] = 0;
                for (int r = 0; r < 3; r++) mCnt[i][r] = 0;
            end else if (!sample) begin
                mMis[i] = 0;
            end else begin
                mMis[i] = (cls != 0);
                if (cls == 4) begin
                    mSt[i] = 3;
                    mUnc[i] = 1;
                end else if (cls != 0 && mSt[i] != 3) begin
                    mCul[i] = cls;
                    if (mCnt[i][cls-1] < maxCnt[i]) mCnt[i][cls-1]++;
                    if (mSt[i] == 0) begin
                        mSt[i] = 1; mTrack[i] = cls; mConsec[i] = 1;
                    end else if (mSt[i] == 1) begin
                        if (cls == mTrack[i]) begin
                            mConsec[i]++;
                            if (mConsec[i] >= THRESH) begin
                                mSt[i] = 2; mAlarm[i] = 1; mARep[i] = cls;
                            end
                        end else begin
                            mTrack[i] = cls; mConsec[i] = 1;
                        end
                    end else if (mSt[i] == 2 && cls != mARep[i]) begin
                        mSt[i] = 3; mUnc[i] = 1;
                    end
                end else if (cls == 0 && mSt[i] == 1) begin
                    mSt[i] = 0; mConsec[i] = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at t=%0t: observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("mismatch",   32'(mis0),   32'(mMis[0]));
        checkOutput("culprit",    32'(cul0),   32'(mCul[0]));
        checkOutput("cnt_a",      32'(ca0),    32'(mCnt[0][0]));
        checkOutput("cnt_b",      32'(cb0),    32'(mCnt[0][1]));
        checkOutput("cnt_c",      32'(cc0),    32'(mCnt[0][2]));
        checkOutput("alarm",      32'(alarm0), 32'(mAlarm[0]));
        checkOutput("alarm_rep",  32'(arep0),  32'(mARep[0]));
        checkOutput("uncorr",     32'(unc0),   32'(mUnc[0]));
        checkOutput("state",      32'(st0),    32'(mSt[0]));
        checkOutput("s_mismatch", 32'(mis1),   32'(mMis[1]));
        checkOutput("s_culprit",  32'(cul1),   32'(mCul[1]));
        checkOutput("s_cnt_a",    32'(ca1),    32'(mCnt[1][0]));
        checkOutput("s_cnt_b",    32'(cb1),    32'(mCnt[1][1]));
        checkOutput("s_cnt_c",    32'(cc1),    32'(mCnt[1][2]));
        checkOutput("s_alarm",    32'(alarm1), 32'(mAlarm[1]));
        checkOutput("s_alarm_rep",32'(arep1),  32'(mARep[1]));
        checkOutput("s_uncorr",   32'(unc1),   32'(mUnc[1]));
        checkOutput("s_state",    32'(st1),    32'(mSt[1]));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // compare every output shortly after the edge.
    task automatic applyStimulus(input logic smp, input logic [DW-1:0] ra, rb, rc,
                                 input logic [2:0] cta, ctb, ctc, input logic clr);
        int cls;
        sample = smp; res_a = ra; res_b = rb; res_c = rc;
        ctrl_a = cta; ctrl_b = ctb; ctrl_c = ctc; clear = clr;
        @(posedge clk);
        cls = modelClassify();
        modelStep(cls);
        #1;
        checkAll();
    endtask

    localparam logic [DW-1:0] BASE = 32'h1234_5678;
    localparam logic [2:0]    CT   = 3'b101;

    // Shorthand: one sample with replica r (1..3) corrupted by a flip mask
    task automatic faultOn(input int r, input logic [DW-1:0] flip);
        applyStimulus(1'b1, (r == 1) ? BASE ^ flip : BASE, (r == 2) ? BASE ^ flip : BASE,
                      (r == 3) ? BASE ^ flip : BASE, CT, CT, CT, 1'b0);
    endtask

    task automatic cleanSample();
        applyStimulus(1'b1, BASE, BASE, BASE, CT, CT, CT, 1'b0);
    endtask

    task automatic doClear();
        applyStimulus(1'b0, BASE, BASE, BASE, CT, CT, CT, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] rnd, fl;
        logic [2:0]    rct, cfl;
        int            pick, rep, lastRep;

        rst_n = 1'b0; sample = 1'b0; clear = 1'b0;
        res_a = '0; res_b = '0; res_c = '0;
        ctrl_a = '0; ctrl_b = '0; ctrl_c = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] clean samples");
        repeat (3) cleanSample();

        $display("[TB] single transient fault on B");
        faultOn(2, 32'h0000_0001);
        checkOutput("t2_mismatch", 32'(mis0), 32'd1);
        checkOutput("t2_culprit",  32'(cul0), 32'd2);
        checkOutput("t2_cnt_b",    32'(cb0),  32'd1);
        checkOutput("t2_state",    32'(st0),  32'd1);
        cleanSample();
        checkOutput("t2_state_ok", 32'(st0),  32'd0);

        $display("[TB] persistent fault on C ctrl ready bit");
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, BASE, BASE, BASE, CT, CT, CT ^ 3'b001, 1'b0);
        checkOutput("t3_alarm",     32'(alarm0), 32'd1);
        checkOutput("t3_alarm_rep", 32'(arep0),  32'd3);
        checkOutput("t3_state",     32'(st0),    32'd2);
        checkOutput("t3_cnt_c",     32'(cc0),    32'd4);
        cleanSample();
        checkOutput("t3_sticky",    32'(st0),    32'd2);
        applyStimulus(1'b0, BASE, BASE, BASE, CT, CT, CT, 1'b0);

        $display("[TB] alternating faults then uncorrectable");
        doClear();
        for (int k = 0; k < 9; k++) faultOn((k % 3) + 1, 32'h8000_0000);
        checkOutput("t4_alarm", 32'(alarm0), 32'd0);
        checkOutput("t4_cnt_a", 32'(ca0), 32'd3);
        checkOutput("t4_cnt_c", 32'(cc0), 32'd3);
        applyStimulus(1'b1, 32'd1, 32'd2, 32'd3, CT, CT, CT, 1'b0);
        checkOutput("t4_uncorr", 32'(unc0), 32'd1);
        checkOutput("t4_state",  32'(st0),  32'd3);
        faultOn(1, 32'h0000_0100);
        checkOutput("t4_frozen", 32'(ca0),  32'd3);

        $display("[TB] saturation and clear priority");
        doClear();
        for (int k = 0; k < 5; k++) faultOn(1, 32'h0000_0010);
        checkOutput("t5_sat", 32'(ca1), 32'd3);
        applyStimulus(1'b1, BASE ^ 32'h1, BASE, BASE, CT, CT, CT, 1'b1);
        checkOutput("t5_clear_cnt", 32'(ca0), 32'd0);
        checkOutput("t5_clear_st",  32'(st0), 32'd0);

        $display("[TB] asynchronous reset in SUSPECT");
        for (int k = 0; k < 3; k++) faultOn(1, 32'h0000_0004);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        #2 rst_n = 1'b1;
        faultOn(1, 32'h0000_0004);
        faultOn(1, 32'h0000_0004);
        faultOn(1, 32'h0000_0004);
        checkOutput("t6_no_alarm", 32'(alarm0), 32'd0);
        checkOutput("t6_suspect",  32'(st0),    32'd1);
        faultOn(1, 32'h0000_0004);
        checkOutput("t6_alarm",    32'(alarm0), 32'd1);

        $display("[TB] randomized traffic");
        doClear();
        lastRep = 1;
        for (int k = 0; k < 600; k++) begin
            rnd  = $urandom;
            rct  = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 99);
            fl   = 32'h1 << $urandom_range(0, 31);
            cfl  = 3'h1 << $urandom_range(0, 2);
            rep  = ($urandom_range(0, 9) < 6) ? lastRep : $urandom_range(1, 3);
            if (pick < 50) begin
                applyStimulus(1'($urandom_range(0, 9) != 0), rnd, rnd, rnd, rct, rct, rct,
                              1'($urandom_range(0, 39) == 0));
            end else if (pick < 94) begin
                lastRep = rep;
                if ($urandom_range(0, 1) == 0)
                    applyStimulus(1'($urandom_range(0, 9) != 0),
                                  (rep == 1) ? rnd ^ fl : rnd, (rep == 2) ? rnd ^ fl : rnd,
                                  (rep == 3) ? rnd ^ fl : rnd, rct, rct, rct,
                                  1'($urandom_range(0, 39) == 0));
                else
                    applyStimulus(1'($urandom_range(0, 9) != 0), rnd, rnd, rnd,
                                  (rep == 1) ? rct ^ cfl : rct, (rep == 2) ? rct ^ cfl : rct,
                                  (rep == 3) ? rct ^ cfl : rct, 1'($urandom_range(0, 39) == 0));
            end else if (pick < 96) begin
                applyStimulus(1'b1, rnd, rnd ^ 32'h1, rnd ^ 32'h2, rct, rct, rct, 1'b0);
            end else begin
                doClear();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
